// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_ctrl
// Brief    : Multi-digit hex 7-segment driver with blink, LZ blanking and dp.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_ctrl #(
  parameter int DIGITS     = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  en,
  input  logic                  lz_blank,
  output logic [7*DIGITS-1:0]   seg,
  output logic [DIGITS-1:0]     dp
);

  localparam int             CNT_W      = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]     c_seg_off  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic           c_dp_off   = (ACTIVE_LOW != 0);

  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_mask;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_phase;

  logic [DIGITS-1:0]   w_lz_zero;
  logic [DIGITS-1:0]   w_blank;
  logic [7*DIGITS-1:0] w_seg_nxt;
  logic [DIGITS-1:0]   w_dp_nxt;

  // Active-high g..a pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
      r_dp    <= '0;
      r_mask  <= '0;
    end else if (load) begin
      r_value <= value;
      r_dp    <= dp_in;
      r_mask  <= blink_mask;
    end
  end

  // Blink timebase is independent of load so a reload never shifts the cadence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (en) begin
      if (r_cnt == c_cnt_last) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // w_lz_zero[k] is set when nibbles DIGITS-1..k are all zero.
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
      if (k == DIGITS - 1) begin : g_top
        assign w_lz_zero[k] = (r_value[4*k +: 4] == 4'h0);
      end else begin : g_rest
        assign w_lz_zero[k] = w_lz_zero[k+1] && (r_value[4*k +: 4] == 4'h0);
      end
    end
  endgenerate

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      logic w_lz_hit;
      if (k == 0) begin : g_d0
        assign w_lz_hit = 1'b0;
      end else begin : g_dn
        assign w_lz_hit = lz_blank && w_lz_zero[k];
      end
      assign w_blank[k] = !en || (r_phase && r_mask[k]) || w_lz_hit;
      assign w_seg_nxt[7*k +: 7] = w_blank[k] ? c_seg_off
                                              : (decode(r_value[4*k +: 4]) ^ c_seg_off);
      assign w_dp_nxt[k] = (w_blank[k] || !r_dp[k]) ? c_dp_off : ~c_dp_off;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= {DIGITS{c_seg_off}};
      dp  <= {DIGITS{c_dp_off}};
    end else begin
      seg <= w_seg_nxt;
      dp  <= w_dp_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_ctrl
// Brief    : Directed self-checking bench for seg_display_ctrl (4 digits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        en = 1'b1;
  logic        lz_blank = 1'b0;
  logic [27:0] seg;
  logic [3:0]  dp;

  int checks = 0;
  int errors = 0;

  seg_display_ctrl #(.DIGITS(4), .BLINK_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .blink_mask(blink_mask), .en(en), .lz_blank(lz_blank), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance until digit 0 has just turned from blank to lit; ok=0 on timeout.
  task automatic sync_lit(output bit ok);
    bit seen_blank = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (seg[6:0] == 7'h7F) seen_blank = 1;
      else if (seen_blank) ok = 1;
    end
  endtask

  task automatic test_reset;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (seg !== 28'hFFFFFFF || dp !== 4'hF) begin
      errors++;
      $display("FAIL reset_async: seg=%h dp=%h expected seg=fffffff dp=f", seg, dp);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (seg !== {4{7'h40}} || dp !== 4'hF) begin
      errors++;
      $display("FAIL reset_first_edge: seg=%h dp=%h expected seg=%h dp=f", seg, dp, {4{7'h40}});
    end
  endtask

  task automatic test_decode;
    logic [15:0] vals [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [27:0] exps [4] = '{{7'h40, 7'h79, 7'h24, 7'h30},
                              {7'h19, 7'h12, 7'h02, 7'h78},
                              {7'h00, 7'h10, 7'h08, 7'h03},
                              {7'h46, 7'h21, 7'h06, 7'h0E}};
    logic [27:0] prev = {4{7'h40}};
    for (int i = 0; i < 4; i++) begin
      value = vals[i]; load = 1'b1;
      tick();
      load = 1'b0;
      checks++;
      if (seg !== prev) begin
        errors++;
        $display("FAIL decode_latency_%0d: seg=%h expected %h", i, seg, prev);
      end
      tick();
      checks++;
      if (seg !== exps[i] || dp !== 4'hF) begin
        errors++;
        $display("FAIL decode_%h: seg=%h dp=%h expected seg=%h dp=f", vals[i], seg, dp, exps[i]);
      end
      prev = exps[i];
    end
  endtask

  task automatic test_leading_zero;
    lz_blank = 1'b1; dp_in = 4'hF; value = 16'h0050; load = 1'b1;
    tick(); load = 1'b0; tick();
    checks++;
    if (seg !== {7'h7F, 7'h7F, 7'h12, 7'h40} || dp !== 4'b1100) begin
      errors++;
      $display("FAIL lz_0050: seg=%h dp=%b expected seg=%h dp=1100", seg, dp, {7'h7F, 7'h7F, 7'h12, 7'h40});
    end
    value = 16'h0000; load = 1'b1;
    tick(); load = 1'b0; tick();
    checks++;
    if (seg !== {7'h7F, 7'h7F, 7'h7F, 7'h40} || dp !== 4'b1110) begin
      errors++;
      $display("FAIL lz_0000: seg=%h dp=%b expected seg=%h dp=1110", seg, dp, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    end
    lz_blank = 1'b0;
    tick();
    checks++;
    if (seg !== {4{7'h40}} || dp !== 4'b0000) begin
      errors++;
      $display("FAIL lz_off_one_edge: seg=%h dp=%b expected seg=%h dp=0000", seg, dp, {4{7'h40}});
    end
  endtask

  task automatic test_blink;
    bit ok;
    logic [6:0] exp0;
    dp_in = 4'b0000; blink_mask = 4'b0001; value = 16'h1234; load = 1'b1;
    tick(); load = 1'b0; tick();
    sync_lit(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL blink_sync: timeout waiting for lit phase, digit0=%h", seg[6:0]);
    end
    // Positions 0..3 lit, 4..7 blank, 8..11 lit again; load issued at position 4.
    for (int p = 1; p < 12; p++) begin
      if (p == 4) begin value = 16'h1235; load = 1'b1; end
      tick();
      load = 1'b0;
      exp0 = (p >= 4 && p < 8) ? 7'h7F : ((p >= 8) ? 7'h12 : 7'h19);
      checks++;
      if (seg[6:0] !== exp0 || seg[27:7] !== {7'h79, 7'h24, 7'h30}) begin
        errors++;
        $display("FAIL blink_pos%0d: seg=%h expected digit0=%h upper=%h", p, seg, exp0, {7'h79, 7'h24, 7'h30});
      end
    end
  endtask

  task automatic test_enable_dp;
    bit ok;
    dp_in = 4'b0100; blink_mask = 4'b0000; value = 16'h1234; load = 1'b1;
    tick(); load = 1'b0; tick();
    checks++;
    if (seg !== {7'h79, 7'h24, 7'h30, 7'h19} || dp !== 4'b1011) begin
      errors++;
      $display("FAIL enable_dp_on: seg=%h dp=%b expected seg=%h dp=1011", seg, dp, {7'h79, 7'h24, 7'h30, 7'h19});
    end
    blink_mask = 4'b0001; load = 1'b1;
    tick(); load = 1'b0;
    sync_lit(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL enable_sync: timeout waiting for lit phase, digit0=%h", seg[6:0]);
    end
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (seg !== 28'hFFFFFFF || dp !== 4'hF) begin
        errors++;
        $display("FAIL enable_off_%0d: seg=%h dp=%h expected seg=fffffff dp=f", i, seg, dp);
      end
    end
    en = 1'b1;
    // Counter frozen mid lit phase: two more lit samples, then four blank.
    for (int p = 0; p < 7; p++) begin
      tick();
      checks++;
      if (seg[6:0] !== ((p >= 2 && p < 6) ? 7'h7F : 7'h19) || dp !== 4'b1011) begin
        errors++;
        $display("FAIL enable_resume_%0d: digit0=%h dp=%b expected digit0=%h dp=1011",
                 p, seg[6:0], dp, (p >= 2 && p < 6) ? 7'h7F : 7'h19);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    dp_in = 4'b0000; blink_mask = 4'b0001; value = 16'h1234; load = 1'b1;
    tick(); load = 1'b0;
    sync_lit(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_sync: timeout waiting for lit phase, digit0=%h", seg[6:0]);
    end
    tick(); tick();
    value = 16'h5678; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (seg !== {7'h79, 7'h24, 7'h30, 7'h19}) begin
      errors++;
      $display("FAIL b2b_wrap_edge: seg=%h expected %h", seg, {7'h79, 7'h24, 7'h30, 7'h19});
    end
    tick();
    checks++;
    if (seg !== {7'h12, 7'h02, 7'h78, 7'h7F}) begin
      errors++;
      $display("FAIL b2b_new_value_phase: seg=%h expected %h", seg, {7'h12, 7'h02, 7'h78, 7'h7F});
    end
  endtask

  task automatic test_reset_mid_load;
    value = 16'hFFFF; dp_in = 4'hF; blink_mask = 4'hF; load = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (seg !== 28'hFFFFFFF || dp !== 4'hF) begin
      errors++;
      $display("FAIL reset_mid_async: seg=%h dp=%h expected seg=fffffff dp=f", seg, dp);
    end
    tick();
    load = 1'b0; rst = 1'b0; blink_mask = 4'h0; dp_in = 4'h0;
    tick();
    checks++;
    if (seg !== {4{7'h40}} || dp !== 4'hF) begin
      errors++;
      $display("FAIL reset_mid_no_partial: seg=%h dp=%h expected seg=%h dp=f", seg, dp, {4{7'h40}});
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_leading_zero();
    test_blink();
    test_enable_dp();
    test_back_to_back();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of hex digits driven, range 1..8.
REQ-002 Parameter BLINK_DIV, default 25000000: clock cycles per blink half-period, minimum 2.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means a lit segment or dp is driven 0; 0 means lit is driven 1.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 load  input  1  capture value, dp_in and blink_mask on this edge.
REQ-008 value  input  4*DIGITS  nibble k drives digit k; digit 0 is least significant.
REQ-009 dp_in  input  DIGITS  decimal-point request per digit.
REQ-010 blink_mask  input  DIGITS  1 means the digit blinks.
REQ-011 en  input  1  display enable; 0 blanks all digits.
REQ-012 lz_blank  input  1  leading-zero blanking enable.
REQ-013 seg  output  7*DIGITS  segments of digit k at bits [7k+6:7k], order g..a (bit 6 = g, bit 0 = a).
REQ-014 dp  output  DIGITS  decimal point per digit.

Function
REQ-015 On load=1, value, dp_in and blink_mask SHALL be registered into value_q, dp_q and mask_q; with load=0 they hold.
REQ-016 Decode, active-high g..a, SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex).
REQ-017 With ACTIVE_LOW=1, the seg and dp outputs SHALL be the bitwise inverse of the active-high pattern.
REQ-018 A blanked digit SHALL drive all 7 segments and its dp unlit.
REQ-019 seg and dp SHALL be registered outputs computed from value_q, dp_q, mask_q, blink phase, en and lz_blank.
  - Latency from a load edge to the updated outputs is exactly 2 clock edges.
  - A change on en or lz_blank reaches the outputs after 1 edge.
REQ-020 Leading-zero blanking: with lz_blank=1, digit k (k>=1) SHALL be blanked when nibbles DIGITS-1..k of value_q are all 0.
  - Digit 0 is never blanked by this rule, so value 0 shows a single "0".
  - The dp of a blanked digit is unlit.
REQ-021 Blink counter: a counter SHALL run 0..BLINK_DIV-1, then wrap to 0.
  - The phase bit toggles on each wrap.
  - The counter and phase run only while en=1, and hold while en=0.
REQ-022 When phase=1, every digit with mask_q bit set SHALL be blanked, segments and dp.
  - When phase=0, the blink mask has no effect.
REQ-023 When en=0, all digits SHALL be blanked regardless of the other inputs.
REQ-024 Blanking priority SHALL be en, then blink, then leading-zero; any one rule active blanks the digit.
REQ-025 load=1 SHALL NOT reset the blink counter or the phase bit.
REQ-026 The block SHALL have no combinational path from any input to seg or dp.

Reset
REQ-027 When rst is asserted, the following SHALL clear asynchronously:
  - value_q, dp_q, mask_q, blink counter and phase to 0;
  - seg and dp to the all-unlit pattern (all 1s when ACTIVE_LOW=1).
REQ-028 On the first edge after rst deasserts, with en=1, outputs SHALL show "0" on digit 0.
  - The other digits show "0" if lz_blank=0, or blank if lz_blank=1.
REQ-029 An rst assertion mid-blink or mid-load SHALL override everything; no partial load survives.

Verification
REQ-030 Bench parameters: DIGITS=4, ACTIVE_LOW=1, BLINK_DIV=4.
REQ-031 Reset: rst=1 -> seg=28'hFFFFFFF and dp=4'hF immediately, without waiting for a clock edge.
REQ-032 Full decode: load each value 0x0123, 0x4567, 0x89AB, 0xCDEF with en=1, lz_blank=0, blink_mask=0.
  - Two edges after each load, seg equals the inverted REQ-016 pattern; for example, digit 0 of 0x89AB (B) = 7'h03.
  - Digit 1 of 0x89AB (A) = 7'h08, and must differ from "9" = 7'h10.
REQ-033 Leading zeros: value=0x0050, lz_blank=1 -> digits 3 and 2 = 7'h7F, digit 1 = 7'h12, digit 0 = 7'h40.
  - Same input with value=0x0000 -> only digit 0 is lit, showing 7'h40.
REQ-034 Blink: blink_mask=4'b0001, value=0x1234, en=1.
  - Digit 0 alternates between 7'h19 ("4") and 7'h7F every 4 cycles.
  - Digits 3..1 stay steady throughout.
  - A load during the blank phase does not shift the toggle timing.
REQ-035 Enable and dp: dp_in=4'b0100, value=0x1234.
  - With en=1, dp=4'b1011.
  - Dropping en to 0 -> one edge later all seg and dp are unlit, and the blink counter is frozen.
  - Raising en again resumes the counter from its frozen value.
REQ-036 Simultaneous events: load and a blink wrap on the same edge.
  - Both take effect.
  - The new value appears with the new phase two edges later.
